// File: rtl/cmd_queue.sv
// Command queue between a host writer and a command processor: first-word-fall-through
// FIFO with sticky overflow and a HALT opcode that stops delivery until flush or reset.
module cmd_queue #(
   parameter int DEPTH = 16,
   parameter int WIDTH = 64
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     host_wr_en,
   input  logic [WIDTH-1:0]         host_wr_data,
   output logic                     host_full,
   input  logic                     flush,
   output logic                     cmd_valid,
   output logic [WIDTH-1:0]         cmd_data,
   input  logic                     cmd_ready,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     overflow,
   output logic                     halt_seen
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [7:0] OP_HALT = 8'h00;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             overflow_q, overflow_d;
   logic             halt_q, halt_d;
   logic             push, pop;

   // All status outputs come from registers only, so cmd_ready never reaches them.
   assign host_full = (count_q == CW'(DEPTH));
   assign cmd_valid = (count_q != '0) && !halt_q;
   assign cmd_data  = mem_q[rd_ptr_q];
   assign count     = count_q;
   assign overflow  = overflow_q;
   assign halt_seen = halt_q;

   assign push = host_wr_en && !host_full && !flush;
   assign pop  = cmd_valid && cmd_ready;

   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      overflow_d = overflow_q;
      halt_d     = halt_q;
      if (flush) begin
         wr_ptr_d   = '0;
         rd_ptr_d   = '0;
         count_d    = '0;
         overflow_d = 1'b0;
         halt_d     = 1'b0;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
         unique case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
         endcase
         // A dropped push is flagged even when a pop frees a slot on the same edge.
         if (host_wr_en && host_full) overflow_d = 1'b1;
         if (pop && (cmd_data[63:56] == OP_HALT)) halt_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
         halt_q     <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
         halt_q     <= halt_d;
      end
   end

   always_ff @(posedge clk) begin
      if (rst_n && push) mem_q[wr_ptr_q] <= host_wr_data;
   end

endmodule

// File: doc/cmd_queue.md
CMD_QUEUE -- requirements
Module: cmd_queue

Interface
REQ-001 Parameter DEPTH, default 16: queue entries; SHALL be a power of two, at least 2.
REQ-002 Parameter WIDTH, default 64: command word width in bits.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 host_wr_en  input  1  host push request for host_wr_data.
REQ-006 host_wr_data  input  WIDTH  command word; bits [63:56] opcode, bit 48 core select.
REQ-007 host_full  output  1  high when count == DEPTH.
REQ-008 flush  input  1  synchronous queue clear.
REQ-009 cmd_valid  output  1  head entry available to the command processor.
REQ-010 cmd_data  output  WIDTH  head entry; first-word-fall-through.
REQ-011 cmd_ready  input  1  consumer accepts the head entry when cmd_valid is also high.
REQ-012 count  output  $clog2(DEPTH)+1  number of stored entries.
REQ-013 overflow  output  1  sticky flag: a push was dropped.
REQ-014 halt_seen  output  1  sticky flag: a HALT opcode (8'h00) was popped.

Function
REQ-015 Storage SHALL be a DEPTH x WIDTH array with write and read pointers of $clog2(DEPTH) bits, each wrapping modulo DEPTH.
REQ-016 A push SHALL be accepted when host_wr_en is high, host_full is low and flush is low; the word is written at the write pointer, which then increments.
REQ-017 A push while host_full is high SHALL be dropped, leave storage unchanged and set overflow to 1 on the next edge; this holds even if a pop occurs in the same cycle.
REQ-018 cmd_valid SHALL equal (count != 0) && !halt_seen; cmd_data SHALL show the entry at the read pointer; cmd_data is don't-care when cmd_valid is low.
REQ-019 A pop SHALL occur when cmd_valid and cmd_ready are both high; the read pointer then increments.
REQ-020 Latency: a word pushed at edge N SHALL be visible on cmd_valid/cmd_data after edge N when the queue was empty: zero-cycle bypass is not used, so the word is first visible in the cycle following the push edge.
REQ-021 On a simultaneous accepted push and pop, count SHALL remain unchanged and both pointers SHALL advance.
REQ-022 count SHALL increment on push-only, decrement on pop-only, and never exceed DEPTH or go below 0.
REQ-023 When a popped word has cmd_data[63:56] == 8'h00, halt_seen SHALL go to 1 on that edge; cmd_valid SHALL be held low from then on until flush or reset. The popped HALT word counts as delivered.
REQ-024 Pushes SHALL still be accepted while halt_seen is 1, subject to REQ-016 and REQ-017.
REQ-025 Flush SHALL zero both pointers, count, overflow and halt_seen on the next edge; a push in the same cycle as flush SHALL be discarded without setting overflow.
REQ-026 No combinational path SHALL exist from cmd_ready to host_full, count or cmd_valid.
REQ-027 cmd_ready high while cmd_valid is low SHALL have no effect.

Reset
REQ-028 While rst_n is low at a rising edge, the pointers, count, overflow and halt_seen SHALL be cleared to 0. As a result, cmd_valid is 0 and host_full is 0.
REQ-029 Array contents need not be reset.
REQ-030 Reset asserted mid-operation SHALL discard all stored entries; the first push after release lands at index 0.
REQ-031 Reset SHALL take priority over flush, push and pop.

Verification
REQ-032 Basic FIFO: push 0x0100_0000_0000_0001 then 0x0201_0000_0000_0002 with cmd_ready=0 -> count=2, cmd_data=...0001; then cmd_ready=1 for 2 cycles -> words delivered in order, count=0, cmd_valid=0.
REQ-033 Full/overflow: with DEPTH=16, push 17 words, no pops -> host_full=1 after the 16th push, 17th dropped, overflow=1; then pop all 16 -> values are words 1..16, wrap-around correct on re-fill.
REQ-034 Simultaneous: at count=16, push and pop in the same cycle -> push dropped, overflow=1, count=15; at count=5, push and pop together -> count stays 5.
REQ-035 Halt: queue holds {0x0A.., 0x00.., 0x0B..}, cmd_ready=1 -> 0x0A and 0x00 words delivered, halt_seen=1, cmd_valid=0, count=1; then flush -> count=0, halt_seen=0.
REQ-036 Reset mid-stream: count=7 and rst_n low for 1 cycle -> count=0, cmd_valid=0, overflow=0; next push appears at cmd_data with count=1.
REQ-037 Stall: hold cmd_ready=0 for 20 cycles with cmd_valid=1 -> cmd_data stable, count unchanged.
